vco_phase_gen: RTL and testbench
================================

// Module: vco_phase_gen
// PURPOSE
//  Digital model of an 11-stage ring-oscillator VCO. Drives the phase_in bus of
//  vco_adc when no analog VCO is present, for on-chip self-test and loopback.
//  A fractional frequency control word sets how many ring stages the phase
//  advances per clk. The output is a Johnson-coded (one-bit-per-step) phase
//  vector, plus a running step count that the ADC sum path must reproduce.
// PARAMETERS
//  PHASE_WIDTH  11  ring stages / phase bus width; must be odd and >= 3
//  FCW_WIDTH    12  frequency control word width, unsigned fixed point
//  FRAC_BITS    8   fractional bits of FCW (1.0 step/clk = 1<<FRAC_BITS)
//  CNT_WIDTH    32  width of the cumulative step counter
// PORTS
//  clk           in   1            system clock, single domain
//  rst           in   1            synchronous reset, active-low
//  enable_in     in   1            1 = oscillate; 0 = freeze all state
//  fcw_load_in   in   1            capture fcw_in into fcw_reg this edge
//  fcw_in        in   FCW_WIDTH    requested steps/clk, FRAC_BITS fractional
//  phase_out     out  PHASE_WIDTH  Johnson-coded ring phase, registered
//  steps_out     out  4            steps taken on the last enabled edge
//  step_count_out out CNT_WIDTH    cumulative steps, wraps modulo 2^CNT_WIDTH
//  fcw_sat_out   out  1            1-cycle pulse: loaded fcw_in was clamped
// BEHAVIOUR
//  - Reset (rst==0 at posedge) clears state s, frac, fcw_reg, phase_out,
//    steps_out, step_count_out and fcw_sat_out to 0. Reset overrides load and
//    enable. It takes effect on the same edge, including mid-run.
//  - Load: on an edge with fcw_load_in=1, fcw_reg <= min(fcw_in, FCW_MAX).
//    FCW_MAX = (PHASE_WIDTH-1)<<FRAC_BITS, which is 2560 for the defaults.
//    The clamp keeps every step below half the ring, so readout cannot alias.
//    fcw_sat_out is 1 on the cycle after a load with fcw_in > FCW_MAX, else 0.
//    Loading is allowed with enable_in=0.
//  - Accumulate: on each edge with enable_in=1 the block computes
//    t = frac + fcw_reg (FRAC_BITS+4 bits), steps = t>>FRAC_BITS (range
//    0..PHASE_WIDTH-1) and frac <= t[FRAC_BITS-1:0]. This uses the fcw_reg
//    value from before the edge, so a load and an accumulate on the same edge
//    use the old word. The new word applies from the next enabled edge.
//  - Ring state: s in 0..2*PHASE_WIDTH-1, updated as s <= (s+steps) mod
//    2*PHASE_WIDTH. The wrap is a single conditional subtract.
//  - Encoding, with N = PHASE_WIDTH and bit i of phase_out:
//    s <  N : bit i = (i < s)      e.g. s=1 -> 0x001, s=11 -> 0x7FF
//    s >= N : bit i = (i >= s-N)   e.g. s=12 -> 0x7FE, s=21 -> 0x400
//    phase_out is registered from the next state, so it changes on the same
//    edge as s and has 1 clk latency from the accumulate. With steps=1,
//    exactly one bit toggles per clk.
//  - steps_out <= steps on each enabled edge.
//    step_count_out <= step_count_out + steps, wrapping silently.
//  - enable_in=0: s, frac, phase_out, steps_out and step_count_out all hold.
//    No steps are lost or replayed when enable returns to 1.
//  - Constant-width arithmetic, no multipliers. State is 5 bits for the
//    defaults (clog2(2*PHASE_WIDTH)).
// TESTING
//  1 Hold rst=0 for 3 clks with random inputs -> every output reads 0 each
//    cycle; release -> outputs stay 0 while fcw_reg=0.
//  2 Load fcw=0x100, enable -> phase_out steps 0x001,0x003,..,0x7FF,0x7FE,
//    ..,0x400,0x000; period 22 clks; steps_out=1; step_count=22 after 22 clks.
//  3 Load fcw=0x080 -> steps_out alternates 0,1 starting with 0;
//    step_count_out=50 after 100 enabled clks.
//  4 Load fcw_in=0xFFF -> fcw_sat_out high for exactly 1 clk; steps_out=10
//    every clk; s advances 0,10,20,8,18; phase_out matches the encoding.
//  5 Drop enable for 5 clks mid-run, load 0x200 while disabled -> outputs
//    frozen; after re-enable steps_out=2, with no step lost or gained.
//  6 Assert rst for 1 clk mid-run at the same edge as fcw_load_in=1 -> all
//    outputs 0 next cycle, load ignored; with step_count_out preset near
//    2^32-1, confirm wrap to a small value.

Source files
------------

// File: rtl/vco_phase_gen.sv
// Digital stand-in for an 11-stage ring-oscillator VCO: a fractional step
// accumulator drives a Johnson-coded ring phase plus a cumulative step count.
module vco_phase_gen #(
  parameter int PHASE_WIDTH = 11,
  parameter int FCW_WIDTH   = 12,
  parameter int FRAC_BITS   = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_in,
  input  logic                   fcw_load_in,
  input  logic [FCW_WIDTH-1:0]   fcw_in,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic [3:0]             steps_out,
  output logic [CNT_WIDTH-1:0]   step_count_out,
  output logic                   fcw_sat_out
);

  localparam int S_W = $clog2(2 * PHASE_WIDTH);
  localparam int T_W = FRAC_BITS + 4;
  // Clamp keeps each step below half the ring so the phase readout cannot alias.
  localparam logic [FCW_WIDTH-1:0] FCW_MAX  = FCW_WIDTH'((PHASE_WIDTH - 1) << FRAC_BITS);
  localparam logic [S_W:0]         RING_LEN = (S_W + 1)'(2 * PHASE_WIDTH);
  localparam logic [S_W-1:0]       N_S      = S_W'(PHASE_WIDTH);

  logic [S_W-1:0]         s;
  logic [FRAC_BITS-1:0]   frac;
  logic [FCW_WIDTH-1:0]   fcw_reg;
  logic [T_W-1:0]         t;
  logic [3:0]             steps;
  logic [S_W:0]           s_sum;
  logic [S_W-1:0]         s_next;
  logic [PHASE_WIDTH-1:0] phase_next;

  always_comb begin
    t          = T_W'(frac) + T_W'(fcw_reg);
    steps      = t[T_W-1:FRAC_BITS];
    s_sum      = {1'b0, s} + (S_W + 1)'(steps);
    s_next     = (s_sum >= RING_LEN) ? S_W'(s_sum - RING_LEN) : S_W'(s_sum);
    phase_next = '0;
    // First half of the ring fills ones from bit 0; second half drains them.
    for (int i = 0; i < PHASE_WIDTH; i++) begin
      if (s_next < N_S) begin
        phase_next[i] = (S_W'(i) < s_next);
      end else begin
        phase_next[i] = (S_W'(i) >= (s_next - N_S));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s              <= '0;
      frac           <= '0;
      fcw_reg        <= '0;
      phase_out      <= '0;
      steps_out      <= '0;
      step_count_out <= '0;
      fcw_sat_out    <= 1'b0;
    end else begin
      fcw_sat_out <= fcw_load_in && (fcw_in > FCW_MAX);
      if (fcw_load_in) begin
        fcw_reg <= (fcw_in > FCW_MAX) ? FCW_MAX : fcw_in;
      end
      // Accumulate uses the pre-edge fcw_reg, so a same-edge load applies next time.
      if (enable_in) begin
        frac           <= t[FRAC_BITS-1:0];
        s              <= s_next;
        phase_out      <= phase_next;
        steps_out      <= steps;
        step_count_out <= step_count_out + CNT_WIDTH'(steps);
      end
    end
  end

endmodule

// File: tb/tb_vco_phase_gen.sv
// Bench for vco_phase_gen: directed tables and sequences plus random traffic,
// all checked against a total-position model of the oscillator.
module tb_vco_phase_gen;

  typedef struct {
    bit          r;
    bit          en;
    bit          ld;
    logic [11:0] f;
    logic [10:0] ph;
    logic [3:0]  st;
    bit          sat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_in = 1'b0;
  logic        fcw_load_in = 1'b0;
  logic [11:0] fcw_in = '0;
  logic [10:0] phase_out;
  logic [3:0]  steps_out;
  logic [31:0] step_count_out;
  logic        fcw_sat_out;
  logic [10:0] p8;
  logic [3:0]  st8;
  logic [7:0]  c8;
  logic        sat8;

  vco_phase_gen dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .fcw_load_in(fcw_load_in),
    .fcw_in(fcw_in), .phase_out(phase_out), .steps_out(steps_out),
    .step_count_out(step_count_out), .fcw_sat_out(fcw_sat_out)
  );

  // Narrow counter instance so the wrap can be reached in a few cycles.
  vco_phase_gen #(.CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .enable_in(enable_in), .fcw_load_in(fcw_load_in),
    .fcw_in(fcw_in), .phase_out(p8), .steps_out(st8),
    .step_count_out(c8), .fcw_sat_out(sat8)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];
  longint      acc = 0;
  int          fcw_m = 0;
  int          steps_m = 0;
  bit          sat_m = 0;
  logic [31:0] base;
  vec_t        t4[6];

  // Ring position s -> Johnson code.
  function automatic logic [10:0] enc(int s);
    int v;
    if (s < 11) v = (1 << s) - 1;
    else        v = 32'h7FF & ~((1 << (s - 11)) - 1);
    return v[10:0];
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cycle(bit r, bit en, bit ld, logic [11:0] f);
    logic [10:0] ph;
    longint      old;
    @(negedge clk);
    rst = r; enable_in = en; fcw_load_in = ld; fcw_in = f;
    @(posedge clk);
    if (!r) begin
      acc = 0; fcw_m = 0; steps_m = 0; sat_m = 0;
    end else begin
      sat_m = ld && (f > 2560);
      if (en) begin
        old = acc >> 8;
        acc = acc + fcw_m;
        steps_m = int'((acc >> 8) - old);
      end
      if (ld) fcw_m = (f > 2560) ? 2560 : int'(f);
    end
    exp_q.push_back(enc(int'((acc >> 8) % 22)));
    #1;
    ph = exp_q.pop_front();
    chk("phase", phase_out, ph);
    chk("steps", steps_out, steps_m);
    chk("count", step_count_out, (acc >> 8) & 64'hFFFF_FFFF);
    chk("sat", fcw_sat_out, sat_m);
    chk("phase8", p8, ph);
    chk("steps8", st8, steps_m);
    chk("count8", c8, (acc >> 8) & 64'hFF);
    chk("sat8", sat8, sat_m);
  endtask

  initial begin
    // Reset held with random inputs, then idle with fcw_reg still 0.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 12'h000);

    // One step per clock: full 22-clock period.
    cycle(1'b1, 1'b0, 1'b1, 12'h100);
    for (int i = 0; i < 22; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 12'h000);
      if (i == 0)  chk("t2_first", phase_out, 11'h001);
      if (i == 11) chk("t2_s12", phase_out, 11'h7FE);
      if (i == 20) chk("t2_s21", phase_out, 11'h400);
    end
    chk("t2_count22", step_count_out, 22);
    chk("t2_wrap", phase_out, 0);

    // Half step per clock.
    cycle(1'b0, 1'b0, 1'b0, 12'h000);
    cycle(1'b1, 1'b0, 1'b1, 12'h080);
    base = step_count_out;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 12'h000);
      chk("t3_alt", steps_out, (i % 2));
    end
    chk("t3_count50", step_count_out - base, 50);

    // Saturating load: table of expected vectors.
    t4[0] = '{r:0, en:0, ld:0, f:12'h000, ph:11'h000, st:4'd0,  sat:0};
    t4[1] = '{r:1, en:0, ld:1, f:12'hFFF, ph:11'h000, st:4'd0,  sat:1};
    t4[2] = '{r:1, en:1, ld:0, f:12'h000, ph:11'h3FF, st:4'd10, sat:0};
    t4[3] = '{r:1, en:1, ld:0, f:12'h000, ph:11'h600, st:4'd10, sat:0};
    t4[4] = '{r:1, en:1, ld:0, f:12'h000, ph:11'h0FF, st:4'd10, sat:0};
    t4[5] = '{r:1, en:1, ld:0, f:12'h000, ph:11'h780, st:4'd10, sat:0};
    for (int i = 0; i < 6; i++) begin
      cycle(t4[i].r, t4[i].en, t4[i].ld, t4[i].f);
      chk("t4_phase", phase_out, t4[i].ph);
      chk("t4_steps", steps_out, t4[i].st);
      chk("t4_sat", fcw_sat_out, t4[i].sat);
    end

    // Freeze with a load while disabled.
    cycle(1'b0, 1'b0, 1'b0, 12'h000);
    cycle(1'b1, 1'b0, 1'b1, 12'h180);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, (i == 2), 12'h200);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 12'h000);
      if (i > 0) chk("t5_steps2", steps_out, 2);
    end

    // Reset coinciding with a load, then counter wrap on the narrow instance.
    cycle(1'b1, 1'b0, 1'b1, 12'hA00);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 12'h000);
    cycle(1'b0, 1'b1, 1'b1, 12'h300);
    chk("t6_rst_phase", phase_out, 0);
    chk("t6_rst_count", step_count_out, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 12'h000);
    chk("t6_load_ignored", steps_out, 0);
    cycle(1'b1, 1'b0, 1'b1, 12'hA00);
    for (int i = 0; i < 40 && ((acc >> 8) % 256) < 250; i++) cycle(1'b1, 1'b1, 1'b0, 12'h000);
    chk("t6_near_max", c8 >= 8'd250, 1);
    cycle(1'b1, 1'b1, 1'b0, 12'h000);
    chk("t6_wrap8_small", c8 < 8'd10, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0), 12'($urandom_range(0, 4095)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
